reg_xfer_ctrl: RTL and testbench

REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

---
 rtl/reg_xfer_ctrl_if.sv | 37 +++
 rtl/reg_xfer_ctrl.sv | 128 ++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_ctrl_if.sv
// Request, register-file and stream signals of reg_xfer_ctrl.
// master = surrounding system / bench, slave = the controller.
interface reg_xfer_ctrl_if #(
   parameter int DW = 16
);
   logic          dump_req;
   logic          load_req;
   logic [2:0]    base;
   logic [3:0]    cnt;
   logic          busy;
   logic          done;
   logic [2:0]    rf_sr1;
   logic [DW-1:0] rf_rdata1;
   logic          rf_we;
   logic [2:0]    rf_dr;
   logic [DW-1:0] rf_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    out_idx;
   logic          out_last;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;

   modport master (
      output dump_req, load_req, base, cnt, rf_rdata1, out_ready, in_valid, in_data,
      input  busy, done, rf_sr1, rf_we, rf_dr, rf_wdata,
      input  out_valid, out_data, out_idx, out_last, in_ready
   );

   modport slave (
      input  dump_req, load_req, base, cnt, rf_rdata1, out_ready, in_valid, in_data,
      output busy, done, rf_sr1, rf_we, rf_dr, rf_wdata,
      output out_valid, out_data, out_idx, out_last, in_ready
   );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-file transfer controller: dumps registers to a ready/valid stream
// or loads a ready/valid stream into registers, with index wrap modulo 8.
module reg_xfer_ctrl #(
   parameter int NREG = 8,
   parameter int DW   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   reg_xfer_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RD, TX, LD, FIN} state_t;

   state_t        state_q;
   logic [2:0]    idx_q;
   logic [3:0]    rem_q;
   logic [2:0]    sr1_q;
   logic [2:0]    dr_q;
   logic [2:0]    oidx_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] odata_q;
   logic          we_q;
   logic          ovalid_q;
   logic          olast_q;
   logic          done_q;
   logic          iready_q;

   logic [3:0]    cnt_dec;
   logic [2:0]    idx_nxt;
   logic          rem_last;

   // 0 and anything above the register count both mean a full sweep
   always_comb begin
      cnt_dec = bus.cnt;
      if (bus.cnt == '0 || bus.cnt > 4'(NREG))
         cnt_dec = 4'(NREG);
   end

   assign idx_nxt  = idx_q + 3'd1;
   assign rem_last = (rem_q == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rem_q    <= '0;
         sr1_q    <= '0;
         dr_q     <= '0;
         oidx_q   <= '0;
         wdata_q  <= '0;
         odata_q  <= '0;
         we_q     <= 1'b0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         done_q   <= 1'b0;
         iready_q <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.dump_req) begin
                  idx_q   <= bus.base;
                  rem_q   <= cnt_dec;
                  sr1_q   <= bus.base;
                  state_q <= RD;
               end else if (bus.load_req) begin
                  idx_q    <= bus.base;
                  rem_q    <= cnt_dec;
                  iready_q <= 1'b1;
                  state_q  <= LD;
               end
            end
            RD: begin
               odata_q  <= bus.rf_rdata1;
               oidx_q   <= idx_q;
               olast_q  <= rem_last;
               ovalid_q <= 1'b1;
               state_q  <= TX;
            end
            TX: begin
               if (bus.out_ready) begin
                  ovalid_q <= 1'b0;
                  if (rem_last) begin
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end else begin
                     idx_q   <= idx_nxt;
                     sr1_q   <= idx_nxt;
                     rem_q   <= rem_q - 4'd1;
                     state_q <= RD;
                  end
               end
            end
            LD: begin
               // in_ready is held high for the whole LD stay, so in_valid alone is the accept
               if (bus.in_valid) begin
                  we_q    <= 1'b1;
                  wdata_q <= bus.in_data;
                  dr_q    <= idx_q;
                  idx_q   <= idx_nxt;
                  rem_q   <= rem_q - 4'd1;
                  if (rem_last) begin
                     iready_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= FIN;
                  end
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.rf_sr1    = sr1_q;
   assign bus.rf_we     = we_q;
   assign bus.rf_dr     = dr_q;
   assign bus.rf_wdata  = wdata_q;
   assign bus.out_valid = ovalid_q;
   assign bus.out_data  = odata_q;
   assign bus.out_idx   = oidx_q;
   assign bus.out_last  = olast_q;
   assign bus.in_ready  = iready_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl: register-file model, scoreboard queues
// for dumped words and expected writes, one task per scenario.
module tb_reg_xfer_ctrl;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  i;
      logic        l;
   } word_t;

   typedef struct {
      logic [2:0]  dr;
      logic [15:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_en = 1'b0;
   always #5 clk = ~clk;

   reg_xfer_ctrl_if #(.DW(16)) bus ();

   reg_xfer_ctrl #(.NREG(8), .DW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] mem     [8];
   logic [15:0] ref_mem [8];
   word_t       exp_q   [$];
   wr_t         wexp_q  [$];
   int          checks   = 0;
   int          failures = 0;

   assign bus.rf_rdata1 = mem[bus.rf_sr1];

   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
      end else if (bus.rf_we === 1'b1) begin
         mem[bus.rf_dr] <= bus.rf_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      bus.dump_req = 0; bus.load_req = 0; bus.base = 0; bus.cnt = 0;
      bus.out_ready = 0; bus.in_valid = 0; bus.in_data = 0;
      rst_n = 0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 16'h1000 + 16'(i);
      init_en = 1;
      @(negedge clk);
      init_en = 0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.rf_we, bus.out_valid, bus.out_last, bus.in_ready} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {bus.busy, bus.done, bus.rf_we, bus.out_valid, bus.out_last, bus.in_ready});
      end
      checks++;
      if ({bus.rf_sr1, bus.rf_dr, bus.out_idx} !== 9'b0) begin
         failures++;
         $display("FAIL reset_indices got sr1=%0d dr=%0d oidx=%0d exp=0",
                  bus.rf_sr1, bus.rf_dr, bus.out_idx);
      end
      checks++;
      if ({bus.out_data, bus.rf_wdata} !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got out_data=%h wdata=%h exp=0", bus.out_data, bus.rf_wdata);
      end
      rst_n = 1;
   endtask

   task automatic do_dump(input logic [2:0] b, input logic [3:0] c, input int stall_word,
                          input int stall_len, input bit dual, input string nm);
      int    n, cyc, first_v, hs_cyc, done_cyc, wcount, stalled, gap_bad, stab_bad, iso_bad;
      bit    prev_v;
      word_t e, held;
      logic [2:0] ix;
      n = (c == 0 || c > 8) ? 8 : int'(c);
      for (int k = 0; k < n; k++) begin
         ix = b + 3'(k);
         exp_q.push_back('{d: ref_mem[ix], i: ix, l: (k == n - 1)});
      end
      bus.base = b; bus.cnt = c; bus.dump_req = 1; bus.load_req = dual;
      bus.out_ready = 0; bus.in_valid = 0;
      @(negedge clk);
      bus.dump_req = 0; bus.load_req = 0;
      bus.base = 3'($urandom); bus.cnt = 4'($urandom);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy_after_req got=%b exp=1", nm, bus.busy);
      end
      first_v = -1; hs_cyc = -1; done_cyc = -1; wcount = 0; stalled = 0;
      gap_bad = 0; stab_bad = 0; iso_bad = 0; prev_v = 0;
      held = '{d: 16'h0, i: 3'h0, l: 1'b0};
      for (cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
         if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b0) iso_bad++;
         if (bus.done === 1'b1) done_cyc = cyc;
         bus.load_req  = dual && (cyc == 4);
         bus.out_ready = 0;
         if (bus.out_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            if (!prev_v && hs_cyc >= 0 && cyc - hs_cyc != 2) gap_bad++;
            if (wcount == stall_word && stalled < stall_len) begin
               if (stalled == 0) held = '{d: bus.out_data, i: bus.out_idx, l: bus.out_last};
               else if ({bus.out_data, bus.out_idx, bus.out_last} !== {held.d, held.i, held.l}) stab_bad++;
               stalled++;
            end else begin
               if (wcount == stall_word && stall_len > 0 &&
                   {bus.out_data, bus.out_idx, bus.out_last} !== {held.d, held.i, held.l}) stab_bad++;
               bus.out_ready = 1;
               hs_cyc = cyc;
               wcount++;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL %s_extra_word got data=%h idx=%0d exp=none", nm, bus.out_data, bus.out_idx);
               end else begin
                  e = exp_q.pop_front();
                  if ({bus.out_data, bus.out_idx, bus.out_last} !== {e.d, e.i, e.l}) begin
                     failures++;
                     $display("FAIL %s_word%0d got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                              nm, wcount - 1, bus.out_data, bus.out_idx, bus.out_last, e.d, e.i, e.l);
                  end
               end
            end
         end
         prev_v = bus.out_valid;
         @(negedge clk);
      end
      bus.out_ready = 0; bus.load_req = 0;
      checks++;
      if (first_v != 2) begin
         failures++;
         $display("FAIL %s_first_latency got=%0d exp=2", nm, first_v);
      end
      checks++;
      if (gap_bad != 0 || stab_bad != 0 || iso_bad != 0) begin
         failures++;
         $display("FAIL %s_protocol got gap_bad=%0d stab_bad=%0d iso_bad=%0d exp=0", nm, gap_bad, stab_bad, iso_bad);
      end
      checks++;
      if (done_cyc < 0 || done_cyc != hs_cyc + 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_done got done_cyc=%0d words_left=%0d exp done_cyc=%0d words_left=0",
                  nm, done_cyc, exp_q.size(), hs_cyc + 1);
      end
      exp_q.delete();
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         failures++;
         $display("FAIL %s_after_done got done,busy=%b exp=00", nm, {bus.done, bus.busy});
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_stays_idle got busy=%b exp=0", nm, bus.busy);
      end
   endtask

   task automatic do_load(input logic [2:0] b, input logic [3:0] c, input int npat,
                          input logic [15:0] vpat, input string nm);
      int  n, cyc, accepted, we_cnt, last_we, done_cyc, we_bad, rdy_bad, iso_bad;
      bit  pend, v, exp_rdy;
      wr_t e;
      logic [15:0] dv;
      n = (c == 0 || c > 8) ? 8 : int'(c);
      bus.base = b; bus.cnt = c; bus.load_req = 1; bus.dump_req = 0; bus.in_valid = 0;
      @(negedge clk);
      bus.load_req = 0;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_busy_after_req got=%b exp=1", nm, bus.busy);
      end
      accepted = 0; we_cnt = 0; last_we = -1; done_cyc = -1;
      we_bad = 0; rdy_bad = 0; iso_bad = 0; pend = 0;
      for (cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
         exp_rdy = (accepted < n);
         if (bus.in_ready !== exp_rdy) rdy_bad++;
         if (bus.out_valid !== 1'b0) iso_bad++;
         if (bus.rf_we !== pend) we_bad++;
         if (bus.rf_we === 1'b1) begin
            we_cnt++;
            last_we = cyc;
            checks++;
            if (wexp_q.size() == 0) begin
               failures++;
               $display("FAIL %s_extra_write got dr=%0d wdata=%h exp=none", nm, bus.rf_dr, bus.rf_wdata);
            end else begin
               e = wexp_q.pop_front();
               ref_mem[e.dr] = e.d;
               if ({bus.rf_dr, bus.rf_wdata} !== {e.dr, e.d}) begin
                  failures++;
                  $display("FAIL %s_write%0d got dr=%0d wdata=%h exp dr=%0d wdata=%h",
                           nm, we_cnt - 1, bus.rf_dr, bus.rf_wdata, e.dr, e.d);
               end
            end
         end
         if (bus.done === 1'b1) done_cyc = cyc;
         pend = 0;
         bus.in_valid = 0;
         bus.in_data = 16'($urandom);
         if (exp_rdy) begin
            v = (cyc - 1 < npat) ? vpat[cyc - 1] : 1'b1;
            if (v) begin
               dv = 16'h00A1 + 16'(accepted);
               bus.in_valid = 1;
               bus.in_data = dv;
               wexp_q.push_back('{dr: b + 3'(accepted), d: dv});
               accepted++;
               pend = 1;
            end
         end
         @(negedge clk);
      end
      bus.in_valid = 0;
      checks++;
      if (we_bad != 0 || rdy_bad != 0 || iso_bad != 0) begin
         failures++;
         $display("FAIL %s_protocol got we_bad=%0d rdy_bad=%0d iso_bad=%0d exp=0", nm, we_bad, rdy_bad, iso_bad);
      end
      checks++;
      if (we_cnt != n || done_cyc < 0 || done_cyc != last_we) begin
         failures++;
         $display("FAIL %s_done got writes=%0d done_cyc=%0d exp writes=%0d done_cyc=%0d",
                  nm, we_cnt, done_cyc, n, last_we);
      end
      wexp_q.delete();
      checks++;
      if ({bus.done, bus.busy, bus.in_ready} !== 3'b000) begin
         failures++;
         $display("FAIL %s_after_done got done,busy,in_ready=%b exp=000", nm, {bus.done, bus.busy, bus.in_ready});
      end
   endtask

   task automatic test_rf_contents(input string nm);
      int bad = 0;
      for (int i = 0; i < 8; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s_rf_contents got %0d differing regs (R0=%h R1=%h R2=%h R6=%h R7=%h) exp R0=%h R1=%h R2=%h R6=%h R7=%h",
                  nm, bad, mem[0], mem[1], mem[2], mem[6], mem[7],
                  ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[6], ref_mem[7]);
      end
   endtask

   // Two words commit, a third is accepted and its write is pending when reset hits.
   task automatic test_load_abort();
      logic [3:0]  vseq = 4'b1011;
      logic [2:0]  pidx = 0;
      logic [15:0] pdat = 0;
      int bad = 0, acc = 0;
      bit pend = 0;
      bus.base = 0; bus.cnt = 5; bus.load_req = 1;
      @(negedge clk);
      bus.load_req = 0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (bus.in_ready !== 1'b1 || bus.rf_we !== pend || bus.done !== 1'b0) bad++;
         if (bus.rf_we === 1'b1) ref_mem[pidx] = pdat;
         pend = vseq[cyc - 1];
         bus.in_valid = pend;
         if (pend) begin
            pidx = 3'(acc);
            pdat = 16'h00B0 + 16'(acc);
            bus.in_data = pdat;
            acc++;
         end
         @(negedge clk);
      end
      bus.in_valid = 0;
      checks++;
      if (bad != 0 || bus.rf_we !== 1'b1) begin
         failures++;
         $display("FAIL abort_prelude got bad=%0d rf_we=%b exp bad=0 rf_we=1", bad, bus.rf_we);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({bus.rf_we, bus.busy, bus.done, bus.in_ready, bus.out_valid} !== 5'b0) begin
         failures++;
         $display("FAIL abort_immediate got we,busy,done,in_ready,out_valid=%b exp=00000",
                  {bus.rf_we, bus.busy, bus.done, bus.in_ready, bus.out_valid});
      end
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_held got bad_cycles=%0d exp=0", bad);
      end
      test_rf_contents("abort");
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      do_dump(3'd0, 4'd0, -1, 0, 1'b0, "dump_full");
      do_load(3'd6, 4'd3, 0, 16'h0, "load_b2b");
      test_rf_contents("load_b2b");
      do_dump(3'd6, 4'd4, 2, 5, 1'b0, "dump_stall");
      do_dump(3'd3, 4'd12, -1, 0, 1'b1, "dump_dual");
      do_load(3'd2, 4'd3, 5, 16'b10101, "load_gaps");
      test_rf_contents("load_gaps");
      test_load_abort();
      do_dump(3'd7, 4'd2, -1, 0, 1'b0, "dump_post_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
